// File: rtl/key_scan.sv
// key_scan: keypad column scanner with press/release debounce plus clear/equal button debouncers
module key_scan #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       i_sys_clock,
    input  logic       i_sys_reset,
    input  logic [3:0] i_key_scan_hex_keypad_row,
    input  logic [3:0] i_key_scan_op_keypad_row,
    input  logic       i_key_scan_clear,
    input  logic       i_key_scan_equal,
    output logic [3:0] o_key_scan_hex_keypad_col,
    output logic [3:0] o_key_scan_op_keypad_col,
    output logic       o_key_scan_hex_valid,
    output logic [3:0] o_key_scan_hex_value,
    output logic       o_key_scan_op_valid,
    output logic [3:0] o_key_scan_op_code,
    output logic       o_key_scan_clear_pulse,
    output logic       o_key_scan_equal_pulse
);
    localparam int SW = $clog2(SETTLE_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

    state_t        state, state_n;
    logic [1:0]    col_idx, col_idx_n;
    logic [SW-1:0] settle_cnt, settle_cnt_n;
    logic [DW-1:0] deb_cnt, deb_cnt_n;
    logic          src_op, src_op_n;
    logic [3:0]    pattern, pattern_n;
    logic          hex_valid_n, op_valid_n;
    logic [3:0]    hex_value_n, op_code_n;
    logic [3:0]    sel_row, key_code;
    logic [1:0]    row_idx;
    logic [1:0]    btn_raw, btn_level, btn_pulse;
    logic [DW-1:0] btn_cnt [2];

    assign sel_row  = src_op ? i_key_scan_op_keypad_row : i_key_scan_hex_keypad_row;
    assign row_idx  = !pattern[0] ? 2'd0 : !pattern[1] ? 2'd1 : !pattern[2] ? 2'd2 : 2'd3;
    assign key_code = {row_idx, col_idx};
    assign btn_raw  = {i_key_scan_equal, i_key_scan_clear};
    assign o_key_scan_clear_pulse = btn_pulse[0];
    assign o_key_scan_equal_pulse = btn_pulse[1];

    // Scan/debounce/hold sequencing: next state, counters and key outputs
    always_comb begin
        state_n      = state;
        col_idx_n    = col_idx;
        settle_cnt_n = settle_cnt;
        deb_cnt_n    = deb_cnt;
        src_op_n     = src_op;
        pattern_n    = pattern;
        hex_valid_n  = 1'b0;
        op_valid_n   = 1'b0;
        hex_value_n  = o_key_scan_hex_value;
        op_code_n    = o_key_scan_op_code;
        case (state)
            SCAN: begin
                if (settle_cnt == SETTLE_LAST) begin
                    deb_cnt_n = '0;
                    if (i_key_scan_hex_keypad_row != 4'hF) begin
                        src_op_n  = 1'b0;
                        pattern_n = i_key_scan_hex_keypad_row;
                        state_n   = DEBOUNCE;
                    end else if (i_key_scan_op_keypad_row != 4'hF) begin
                        src_op_n  = 1'b1;
                        pattern_n = i_key_scan_op_keypad_row;
                        state_n   = DEBOUNCE;
                    end else begin
                        col_idx_n    = col_idx + 2'd1;
                        settle_cnt_n = '0;
                    end
                end else begin
                    settle_cnt_n = settle_cnt + SW'(1);
                end
            end
            DEBOUNCE: begin
                if (sel_row != pattern) begin
                    state_n      = SCAN;
                    col_idx_n    = col_idx + 2'd1;
                    settle_cnt_n = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_n     = HOLD;
                    deb_cnt_n   = '0;
                    hex_valid_n = !src_op;
                    op_valid_n  = src_op;
                    hex_value_n = src_op ? o_key_scan_hex_value : key_code;
                    op_code_n   = src_op ? key_code : o_key_scan_op_code;
                end else begin
                    deb_cnt_n = deb_cnt + DW'(1);
                end
            end
            HOLD: begin
                if (sel_row != 4'hF) begin
                    deb_cnt_n = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_n      = SCAN;
                    col_idx_n    = col_idx + 2'd1;
                    settle_cnt_n = '0;
                end else begin
                    deb_cnt_n = deb_cnt + DW'(1);
                end
            end
            default: state_n = SCAN;
        endcase
    end

    // Scan FSM state register and registered key outputs
    always_ff @(posedge i_sys_clock) begin
        if (i_sys_reset) begin
            state                     <= SCAN;
            col_idx                   <= 2'd0;
            settle_cnt                <= '0;
            deb_cnt                   <= '0;
            src_op                    <= 1'b0;
            pattern                   <= 4'hF;
            o_key_scan_hex_keypad_col <= 4'b1110;
            o_key_scan_op_keypad_col  <= 4'b1110;
            o_key_scan_hex_valid      <= 1'b0;
            o_key_scan_op_valid       <= 1'b0;
            o_key_scan_hex_value      <= 4'h0;
            o_key_scan_op_code        <= 4'h0;
        end else begin
            state                     <= state_n;
            col_idx                   <= col_idx_n;
            settle_cnt                <= settle_cnt_n;
            deb_cnt                   <= deb_cnt_n;
            src_op                    <= src_op_n;
            pattern                   <= pattern_n;
            o_key_scan_hex_keypad_col <= ~(4'b0001 << col_idx_n);
            o_key_scan_op_keypad_col  <= ~(4'b0001 << col_idx_n);
            o_key_scan_hex_valid      <= hex_valid_n;
            o_key_scan_op_valid       <= op_valid_n;
            o_key_scan_hex_value      <= hex_value_n;
            o_key_scan_op_code        <= op_code_n;
        end
    end

    // Clear/equal debouncers: level follows raw after a full run of disagreement, pulse on rise
    always_ff @(posedge i_sys_clock) begin
        for (int i = 0; i < 2; i++) begin
            if (i_sys_reset) begin
                btn_cnt[i]   <= '0;
                btn_level[i] <= 1'b0;
                btn_pulse[i] <= 1'b0;
            end else if (btn_raw[i] == btn_level[i]) begin
                btn_cnt[i]   <= '0;
                btn_pulse[i] <= 1'b0;
            end else if (btn_cnt[i] == DEB_LAST) begin
                btn_cnt[i]   <= '0;
                btn_level[i] <= btn_raw[i];
                btn_pulse[i] <= btn_raw[i];
            end else begin
                btn_cnt[i]   <= btn_cnt[i] + DW'(1);
                btn_pulse[i] <= 1'b0;
            end
        end
    end
endmodule
